// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
package down_timer_pkg;

  // Default counter / load-value width.
  localparam int DEFAULT_WIDTH = 4;

  // Controller states. busy is asserted in RUN and PAUSED only.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_e;

endpackage : down_timer_pkg

// File: rtl/down_timer_if.sv
// Control/status bundle of the down_timer.
// The master side drives the strobes and levels; the slave side is the timer.
interface down_timer_if
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             tick;
  logic             auto_reload;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output load, load_val, start, pause, tick, auto_reload,
    input  cnt, busy, tc, done
  );

  modport slave (
    input  load, load_val, start, pause, tick, auto_reload,
    output cnt, busy, tc, done
  );

endinterface : down_timer_if

// File: rtl/down_timer.sv
// Loadable down-counting timer with pause, optional auto-reload and a
// sticky done flag. All outputs come straight from registers.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  down_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  timer_state_e     state_r;
  timer_state_e     state_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
  logic             tc_r;
  logic             tc_s;
  logic             done_r;
  logic             done_s;
  logic             busy_r;
  logic             busy_s;

  // Next-state logic: load beats start, start beats pause, pause beats tick.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    reload_s = reload_r;
    tc_s     = 1'b0;
    done_s   = done_r;

    if (bus.load) begin
      // Load aborts any count in progress and parks the timer in IDLE.
      cnt_s    = bus.load_val;
      reload_s = bus.load_val;
      state_s  = IDLE;
      done_s   = 1'b0;
    end else if (bus.start) begin
      // Start (or restart) from the reload value; a zero reload finishes at once.
      cnt_s = reload_r;
      if (reload_r != ZERO_C) begin
        state_s = RUN;
        done_s  = 1'b0;
      end else begin
        state_s = DONE;
        tc_s    = 1'b1;
        done_s  = 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RUN: begin
          if (bus.pause) begin
            state_s = PAUSED;
          end else if (bus.tick) begin
            if (cnt_r > ONE_C) begin
              cnt_s = cnt_r - ONE_C;
            end else if (cnt_r == ONE_C) begin
              tc_s = 1'b1;
              if (bus.auto_reload) begin
                cnt_s   = reload_r;
                state_s = RUN;
              end else begin
                cnt_s   = ZERO_C;
                state_s = DONE;
                done_s  = 1'b1;
              end
            end else begin
              // cnt of zero while running is unreachable; finish without wrapping.
              cnt_s   = ZERO_C;
              state_s = DONE;
              done_s  = 1'b1;
            end
          end else begin
            state_s = RUN;
          end
        end
        PAUSED: begin
          // The release cycle only returns to RUN; a tick here is not counted.
          if (bus.pause) begin
            state_s = PAUSED;
          end else begin
            state_s = RUN;
          end
        end
        DONE: begin
          cnt_s  = ZERO_C;
          done_s = 1'b1;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = ZERO_C;
          done_s  = 1'b0;
        end
      endcase
    end

    busy_s = (state_s == RUN) || (state_s == PAUSED);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= ZERO_C;
      reload_r <= ZERO_C;
      tc_r     <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      reload_r <= reload_s;
      tc_r     <= tc_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
    end
  end

  assign bus.cnt  = cnt_r;
  assign bus.busy = busy_r;
  assign bus.tc   = tc_r;
  assign bus.done = done_r;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer (WIDTH = 4).
module tb_down_timer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  down_timer_if #(.WIDTH(4)) bus ();

  down_timer #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic b,
                         input logic t, input logic d);
    chk({tag, ".cnt"},  {4'd0, bus.cnt},  {4'd0, c});
    chk({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, b});
    chk({tag, ".tc"},   {7'd0, bus.tc},   {7'd0, t});
    chk({tag, ".done"}, {7'd0, bus.done}, {7'd0, d});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n           = 1'b0;
    bus.load        = 1'b0;
    bus.load_val    = 4'd0;
    bus.start       = 1'b0;
    bus.pause       = 1'b0;
    bus.tick        = 1'b0;
    bus.auto_reload = 1'b0;

    // Reset / idle
    cyc(); cyc();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk_all("idle0", 4'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_all("idle1", 4'd0, 1'b0, 1'b0, 1'b0);

    // Basic count from 3
    bus.load_val = 4'd3; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    chk_all("basic.load", 4'd3, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1; bus.tick = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_all("basic.c3", 4'd3, 1'b1, 1'b0, 1'b0);
    cyc(); chk_all("basic.c2", 4'd2, 1'b1, 1'b0, 1'b0);
    cyc(); chk_all("basic.c1", 4'd1, 1'b1, 1'b0, 1'b0);
    cyc(); chk_all("basic.tc", 4'd0, 1'b0, 1'b1, 1'b1);
    cyc(); chk_all("basic.hold", 4'd0, 1'b0, 1'b0, 1'b1);

    // Pause and tick gating from 5
    bus.tick = 1'b0;
    bus.load_val = 4'd5; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    chk_all("pause.load", 4'd5, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_all("pause.start", 4'd5, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b1; cyc(); chk_all("pause.c4", 4'd4, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b0; cyc(); chk_all("pause.c4h", 4'd4, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b1; cyc(); chk_all("pause.c3", 4'd3, 1'b1, 1'b0, 1'b0);
    bus.pause = 1'b1;
    bus.tick = 1'b0; cyc(); chk_all("pause.p1", 4'd3, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b1; cyc(); chk_all("pause.p2", 4'd3, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b0; cyc(); chk_all("pause.p3", 4'd3, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b1; cyc(); chk_all("pause.p4", 4'd3, 1'b1, 1'b0, 1'b0);
    bus.pause = 1'b0;
    bus.tick = 1'b1; cyc(); chk_all("pause.resume", 4'd3, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b0; cyc(); chk_all("pause.r3h", 4'd3, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b1; cyc(); chk_all("pause.r2", 4'd2, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b0; cyc(); chk_all("pause.r2h", 4'd2, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b1; cyc(); chk_all("pause.r1", 4'd1, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b0; cyc(); chk_all("pause.r1h", 4'd1, 1'b1, 1'b0, 1'b0);
    bus.tick = 1'b1; cyc(); chk_all("pause.tc", 4'd0, 1'b0, 1'b1, 1'b1);

    // Auto-reload with value 2
    bus.tick = 1'b0;
    bus.load_val = 4'd2; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.auto_reload = 1'b1; bus.tick = 1'b1; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_all("ar.c2", 4'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_all("ar.c1", 4'd1, 1'b1, 1'b0, 1'b0);
      cyc(); chk_all("ar.reload", 4'd2, 1'b1, 1'b1, 1'b0);
    end
    bus.auto_reload = 1'b0;

    // Abort by simultaneous load+start at cnt=4 of 9
    bus.load_val = 4'd9; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_all("abort.c9", 4'd9, 1'b1, 1'b0, 1'b0);
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk_all("abort.c4", 4'd4, 1'b1, 1'b0, 1'b0);
    bus.load_val = 4'd7; bus.load = 1'b1; bus.start = 1'b1;
    cyc();
    bus.load = 1'b0; bus.start = 1'b0;
    chk_all("abort.load7", 4'd7, 1'b0, 1'b0, 1'b0);
    cyc(); chk_all("abort.idle", 4'd7, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_all("abort.run7", 4'd7, 1'b1, 1'b0, 1'b0);
    cyc(); chk_all("abort.c6", 4'd6, 1'b1, 1'b0, 1'b0);

    // Zero load then start finishes immediately
    bus.load_val = 4'd0; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    chk_all("zero.load", 4'd0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_all("zero.tc", 4'd0, 1'b0, 1'b1, 1'b1);
    cyc(); chk_all("zero.hold", 4'd0, 1'b0, 1'b0, 1'b1);

    // Maximum value 15 counts fully down
    bus.load_val = 4'd15; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_all("max.c15", 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 14; i >= 1; i--) begin
      cyc(); chk_all("max.dec", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    cyc(); chk_all("max.tc", 4'd0, 1'b0, 1'b1, 1'b1);

    // Restart from DONE, then reset mid-count
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_all("rst.c15", 4'd15, 1'b1, 1'b0, 1'b0);
    cyc(); cyc();
    chk_all("rst.c13", 4'd13, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc();
    chk_all("rst.clear", 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk_all("rst.reload0", 4'd0, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_down_timer

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable, programmable down-counting timer; the count-down counterpart of the team's free-running up counter.
- Counts a loaded value down to zero on qualified ticks and flags terminal count.
- Optional auto-reload, pause/resume, and sticky done.
- Sits beside the up counters as the generic interval/timeout source for lab designs.

Parameters:
WIDTH, 4, counter and load-value width in bits (legal values ≥ 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
load  input  1  one-cycle strobe: capture load_val into counter and reload register
load_val  input  WIDTH  value taken on load
start  input  1  one-cycle strobe: begin or restart counting
pause  input  1  level: hold count while high
tick  input  1  count enable (prescaled strobe or tied high)
auto_reload  input  1  level: on terminal count reload and keep running
cnt  output  WIDTH  current count (registered)
busy  output  1  high in RUN or PAUSED
tc  output  1  one-cycle terminal-count pulse (registered)
done  output  1  sticky: set on non-reloading terminal count

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. Sampled only on a rising clk edge; no asynchronous path.
- Reset values:
  - cnt=0, reload register=0, state=IDLE.
  - busy=0, tc=0, done=0.
- States: IDLE, RUN, PAUSED, DONE. busy is high in RUN and PAUSED only.
- Priority each cycle: reset > load > start > pause > tick.
- load, any state:
  - cnt and reload register take load_val; state goes to IDLE; done is cleared; tc is 0.
  - A load during RUN or PAUSED aborts the count.
- start in IDLE or DONE:
  - cnt takes the reload register and done clears.
  - If the reload register is non-zero, state goes to RUN.
  - If it is zero, the next cycle has state DONE, tc=1, done=1.
  - start in RUN or PAUSED restarts: cnt takes the reload register and the state stays RUN.
- RUN:
  - pause=1: go to PAUSED; cnt is frozen and ticks are ignored.
  - tick=1 and cnt>1: cnt decrements by 1.
  - tick=1 and cnt==1: tc=1 for exactly that next cycle.
    - auto_reload=1: cnt takes the reload register and the state stays RUN.
    - auto_reload=0: cnt=0, state DONE, done=1.
  - tick=0: hold.
- PAUSED: pause=0 returns to RUN on the next cycle; cnt is unchanged and a tick in the release cycle is ignored.
- DONE:
  - cnt holds 0 and done holds 1 until load or start.
  - tick and pause are ignored.
- Latency: from a start in cycle k with tick tied high, RUN begins in k+1. cnt=N is visible in k+1, and cnt reaches 0 with tc=1 in k+1+N.
- tc is never high two consecutive cycles, except with auto_reload and a reload value of 1 and tick tied high. In that case tc is high every cycle, which is intended.
- No wrap-around: cnt never decrements below 0; arithmetic is unsigned WIDTH-bit.
- A load of 0 followed by start finishes immediately (see start).
- Reset during RUN or PAUSED returns everything to the reset values on the next edge.
- A load and start in the same cycle: the load wins and start is dropped.

Decomposition:
- Shared package: state enum (IDLE/RUN/PAUSED/DONE) and the default WIDTH constant.
- Single module. No sub-module; the prescaler that drives tick lives outside.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles then 1, no other stimulus -> cnt=0, busy=0, tc=0, done=0 and held.
- Basic count: load_val=3, load, start, tick=1 -> cnt 3,2,1,0 on consecutive cycles; tc=1 and done=1 with cnt=0; busy drops the same cycle.
- Pause and tick gating:
  - load 5, start, tick every 2nd cycle, pause high for 4 cycles at cnt=3.
  - Required: cnt stays at 3 while paused; total count to 0 extended by the pause plus the 1 resume cycle.
- Auto-reload: load 2, auto_reload=1, tick=1 -> cnt 2,1,2,1,2... with tc pulsing each time cnt would reach 0; done stays 0.
- Abort and priority:
  - Mid-count (cnt=4 of 9), assert load with load_val=7 and start in the same cycle -> cnt=7, state IDLE, busy=0.
  - A following start -> RUN from 7.
- Zero and max boundaries:
  - load 0 then start -> tc=1 and done=1 the next cycle.
  - load 15 (WIDTH=4), start -> 15 ticks to tc; reset asserted mid-count clears all outputs the next cycle.
